// File: rtl/spi_shifter_pkg.sv
// Shared constants and state encoding for the SPI byte shifter and future multi-byte controller.
package spi_shifter_pkg;

  localparam int SPI_WORD  = 8;
  localparam int BIT_CNT_W = 4;
  localparam int TMR_W     = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    START = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// 8-bit shift register with parallel load and serial in/out; bit order set by MSB_FIRST.
// Latency: one cycle per load or shift; load wins over shift.
// Backpressure: none, operations are accepted every cycle.
module spi_shift_reg
  import spi_shifter_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                load,
  input  logic [SPI_WORD-1:0] load_dat,
  input  logic                shift,
  input  logic                ser_in,
  output logic                ser_out,
  output logic [SPI_WORD-1:0] par_dat
);

  logic [SPI_WORD-1:0] sr_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_dat;
    end else if (shift) begin
      sr_q <= MSB_FIRST ? {sr_q[SPI_WORD-2:0], ser_in} : {ser_in, sr_q[SPI_WORD-1:1]};
    end
  end

  // The wire-side bit is whichever end leaves first.
  assign ser_out = MSB_FIRST ? sr_q[SPI_WORD-1] : sr_q[0];
  assign par_dat = sr_q;

endmodule

// File: rtl/spi_shifter.sv
// SPI mode-0 byte transceiver driven by the SCLK divider's idle flag and edge strobes.
// Latency: CS_SETUP + 1 + divider transfer + CS_HOLD + 1 cycles from handshake to o_rx_valid.
// Backpressure: o_tx_ready only in IDLE; i_tx_valid is ignored and must be held otherwise.
module spi_shifter
  import spi_shifter_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_busy,
  output logic       o_cs_n,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic       o_div_start_n,
  input  logic       i_div_idle,
  input  logic       i_div_rising_edge,
  input  logic       i_div_falling_edge
);

  localparam logic [TMR_W-1:0]     SETUP_LAST = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0]     HOLD_LAST  = TMR_W'(CS_HOLD - 1);
  localparam logic [BIT_CNT_W-1:0] CNT_FULL   = BIT_CNT_W'(SPI_WORD);

  state_t                state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [SPI_WORD-1:0]   rx_dat_q;

  logic                  tx_load, tx_shift, rx_shift, rx_capture;
  logic                  bits_done;
  logic                  tx_ser_out, rx_ser_out;
  logic [SPI_WORD-1:0]   tx_par_dat, rx_par_dat;
  logic                  unused_bits;

  assign bits_done = (bit_cnt_q == CNT_FULL);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tmr_d      = tmr_q;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    rx_shift   = 1'b0;
    rx_capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_tx_valid && o_tx_ready) begin
          tx_load   = 1'b1;
          bit_cnt_d = '0;
          tmr_d     = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        // Once the setup time has elapsed, wait here while the divider is busy.
        if (tmr_q == SETUP_LAST) begin
          if (i_div_idle) begin
            state_d = START;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      START: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        // Rising takes priority; a simultaneous falling strobe is dropped.
        if (!bits_done) begin
          if (i_div_rising_edge) begin
            rx_shift  = 1'b1;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end else if (i_div_falling_edge) begin
            tx_shift = 1'b1;
          end
        end else if (i_div_idle) begin
          tmr_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          rx_capture = 1'b1;
          state_d    = DONE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tmr_q     <= '0;
      rx_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tmr_q     <= tmr_d;
      if (rx_capture) begin
        rx_dat_q <= rx_par_dat;
      end
    end
  end

  // MOSI holds its last bit between bytes because the tx register only moves on load/shift.
  spi_shift_reg #(.MSB_FIRST(MSB_FIRST)) u_tx_sr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .load     (tx_load),
    .load_dat (i_tx_data),
    .shift    (tx_shift),
    .ser_in   (1'b0),
    .ser_out  (tx_ser_out),
    .par_dat  (tx_par_dat)
  );

  // Shifting toward the first-bit end leaves the received byte in natural bit order.
  spi_shift_reg #(.MSB_FIRST(MSB_FIRST)) u_rx_sr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .load     (tx_load),
    .load_dat ('0),
    .shift    (rx_shift),
    .ser_in   (i_miso),
    .ser_out  (rx_ser_out),
    .par_dat  (rx_par_dat)
  );

  assign unused_bits = ^{tx_par_dat, rx_ser_out};

  assign o_tx_ready    = i_rst_n && (state_q == IDLE);
  assign o_busy        = (state_q != IDLE);
  assign o_cs_n        = !((state_q == SETUP) || (state_q == START) ||
                           (state_q == SHIFT) || (state_q == HOLD));
  assign o_mosi        = tx_ser_out;
  assign o_div_start_n = (state_q != START);
  assign o_rx_valid    = (state_q == DONE);
  assign o_rx_data     = rx_dat_q;

  strobe_overlap_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == SHIFT) |-> !(i_div_rising_edge && i_div_falling_edge));

endmodule
